// File: rtl/i2c_pkg.sv
// Shared definitions for the single-byte I2C master: FSM state encoding,
// quarter-phase constants and the default slave address.
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE,
    START,
    ADDR,
    ADDR_ACK,
    WR_DATA,
    WR_ACK,
    RD_DATA,
    RD_NACK,
    STOP
  } i2c_state_e;

  // Quarter phases of one SCL bit period
  localparam logic [1:0] Q0 = 2'd0;  // SCL low, SDA updated
  localparam logic [1:0] Q1 = 2'd1;  // SCL released
  localparam logic [1:0] Q2 = 2'd2;  // SCL high, SDA sampled at the end
  localparam logic [1:0] Q3 = 2'd3;  // SCL pulled low

  localparam logic [6:0] I2C_DEFAULT_ADDR = 7'b1110010;

endpackage

// File: rtl/i2c_qtick_gen.sv
// Quarter-period timebase: one-clk qtick every CLK_DIV clks while enabled.
// hold_i freezes the divider (used for slave clock stretching).
module i2c_qtick_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic hold_i,
  output logic qtick_o
);

  localparam int CNT_W = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic             tick_q;

  // Divider counter; restarts from zero whenever the master is idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else if (!en_i) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else if (hold_i) begin
      tick_q <= 1'b0;
    end else begin
      tick_q <= (cnt_q == CNT_LAST);
      cnt_q  <= (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  assign qtick_o = tick_q;

endmodule

// File: rtl/i2c_master_ctrl.sv
// Single-byte I2C master: START, address, one data byte (write or read),
// STOP. Open-drain SDA/SCL. Optional macro I2C_MASTER_CLK_STRETCH_EN lets a
// slave stretch SCL by holding the timebase in Q1 while scl reads low.
module i2c_master_ctrl
  import i2c_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int ADDR_W  = 7,
  parameter int DATA_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] addr,
  input  logic              rw,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              ready,
  output logic              done,
  output logic              ack_err,
  inout  wire               sda,
  inout  wire               scl
);

  localparam int BIT_W = $clog2(DATA_W);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

  i2c_state_e        state_q, state_d;
  logic [1:0]        q_q, q_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rw_q, rw_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rx_q, rx_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              nack_q, nack_d;
  logic              ack_err_q, ack_err_d;
  logic              done_q, done_d;
  logic              qtick, hold;
  logic              sda_low, scl_low;
  logic [ADDR_W:0]   abyte;

  assign abyte = {addr_q, rw_q};

`ifdef I2C_MASTER_CLK_STRETCH_EN
  assign hold = (state_q != IDLE) && (q_q == Q1) && (scl == 1'b0);
`else
  assign hold = 1'b0;
`endif

  i2c_qtick_gen #(.CLK_DIV(CLK_DIV)) u_qtick (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   (state_q != IDLE),
    .hold_i (hold),
    .qtick_o(qtick)
  );

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      q_q       <= Q0;
      bit_q     <= BIT_LAST;
      addr_q    <= '0;
      rw_q      <= 1'b0;
      wdata_q   <= '0;
      rx_q      <= '0;
      rdata_q   <= '0;
      nack_q    <= 1'b0;
      ack_err_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      q_q       <= q_d;
      bit_q     <= bit_d;
      addr_q    <= addr_d;
      rw_q      <= rw_d;
      wdata_q   <= wdata_d;
      rx_q      <= rx_d;
      rdata_q   <= rdata_d;
      nack_q    <= nack_d;
      ack_err_q <= ack_err_d;
      done_q    <= done_d;
    end
  end

  // Next state: quarters advance on qtick, samples taken at end of Q2,
  // state moves at end of Q3
  always_comb begin
    state_d   = state_q;
    q_d       = q_q;
    bit_d     = bit_q;
    addr_d    = addr_q;
    rw_d      = rw_q;
    wdata_d   = wdata_q;
    rx_d      = rx_q;
    rdata_d   = rdata_q;
    nack_d    = nack_q;
    ack_err_d = ack_err_q;
    done_d    = 1'b0;
    if (state_q == IDLE) begin
      if (start) begin
        state_d   = START;
        q_d       = Q0;
        bit_d     = BIT_LAST;
        addr_d    = addr;
        rw_d      = rw;
        wdata_d   = wdata;
        ack_err_d = 1'b0;
      end
    end else if (qtick) begin
      q_d = q_q + 2'd1;
      if (q_q == Q2) begin
        if (state_q == ADDR_ACK) nack_d = sda;
        if (state_q == RD_DATA)  rx_d   = {rx_q[DATA_W-2:0], sda};
      end
      if (q_q == Q3) begin
        case (state_q)
          START: begin
            state_d = ADDR;
            bit_d   = BIT_LAST;
          end
          ADDR: begin
            if (bit_q == '0) state_d = ADDR_ACK;
            else             bit_d   = bit_q - 1'b1;
          end
          ADDR_ACK: begin
            bit_d = BIT_LAST;
            if (nack_q) begin
              ack_err_d = 1'b1;
              state_d   = STOP;
            end else begin
              state_d = rw_q ? RD_DATA : WR_DATA;
            end
          end
          WR_DATA: begin
            if (bit_q == '0) state_d = WR_ACK;
            else             bit_d   = bit_q - 1'b1;
          end
          WR_ACK: state_d = STOP;
          RD_DATA: begin
            if (bit_q == '0) state_d = RD_NACK;
            else             bit_d   = bit_q - 1'b1;
          end
          RD_NACK: begin
            rdata_d = rx_q;
            state_d = STOP;
          end
          STOP: begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
          default: state_d = IDLE;
        endcase
      end
    end
  end

  // Bus drive decode: SCL low in Q0/Q3 of every bit, START/STOP shapes
  always_comb begin
    sda_low = 1'b0;
    scl_low = 1'b0;
    case (state_q)
      START: sda_low = q_q[1];
      ADDR: begin
        sda_low = ~abyte[bit_q];
        scl_low = (q_q == Q0) || (q_q == Q3);
      end
      WR_DATA: begin
        sda_low = ~wdata_q[bit_q];
        scl_low = (q_q == Q0) || (q_q == Q3);
      end
      ADDR_ACK, WR_ACK, RD_DATA, RD_NACK: scl_low = (q_q == Q0) || (q_q == Q3);
      STOP: begin
        sda_low = ~q_q[1];
        scl_low = (q_q == Q0);
      end
      default: ;
    endcase
  end

  assign sda     = sda_low ? 1'b0 : 1'bz;
  assign scl     = scl_low ? 1'b0 : 1'bz;
  assign ready   = (state_q == IDLE);
  assign done    = done_q;
  assign ack_err = ack_err_q;
  assign rdata   = rdata_q;

endmodule
